// File: rtl/seq_calci.sv
// Multi-cycle unsigned calculator: add/sub in one EXEC cycle, shift-add multiply and
// restoring divide in WIDTH EXEC cycles, with a start/busy/done handshake and div-by-zero flag.
module seq_calci #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_t;

    state_t               state, state_next;
    op_t                  op_r;
    logic [WIDTH-1:0]     a_r, b_r;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   prod, mcand, prod_next;
    logic [WIDTH-1:0]     shreg, rem, rem_next, quo_next;
    logic [WIDTH:0]       trial, diff;
    logic                 ge, last_iter, exec_final, div_zero;

    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign div_zero  = (b_r == '0);

    always_comb begin
        exec_final = 1'b0;
        case (op_r)
            OP_ADD, OP_SUB: exec_final = 1'b1;
            OP_MUL:         exec_final = last_iter;
            OP_DIV:         exec_final = div_zero || last_iter;
            default:        exec_final = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = EXEC;
            end
            EXEC: if (exec_final) state_next = DONE;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // shreg holds the multiplier (shifted right) for mul and the dividend/quotient (shifted left) for div
    always_comb begin
        prod_next = shreg[0] ? prod + mcand : prod;
        trial     = {rem, shreg[WIDTH-1]};
        ge        = (trial >= {1'b0, b_r});
        diff      = trial - {1'b0, b_r};
        rem_next  = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_next  = {shreg[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r   <= OP_ADD;
            a_r    <= '0;
            b_r    <= '0;
            cnt    <= '0;
            prod   <= '0;
            mcand  <= '0;
            shreg  <= '0;
            rem    <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_r  <= op_t'(op);
                    a_r   <= a;
                    b_r   <= b;
                    cnt   <= '0;
                    prod  <= '0;
                    rem   <= '0;
                    mcand <= {{WIDTH{1'b0}}, a};
                    shreg <= (op_t'(op) == OP_DIV) ? a : b;
                end
                EXEC: begin
                    case (op_r)
                        OP_ADD: begin
                            result <= {{WIDTH{1'b0}}, a_r} + {{WIDTH{1'b0}}, b_r};
                            err    <= 1'b0;
                        end
                        OP_SUB: begin
                            result <= {{WIDTH{1'b0}}, a_r} - {{WIDTH{1'b0}}, b_r};
                            err    <= 1'b0;
                        end
                        OP_MUL: begin
                            prod  <= prod_next;
                            mcand <= mcand << 1;
                            shreg <= shreg >> 1;
                            cnt   <= cnt + CW'(1);
                            if (last_iter) begin
                                result <= prod_next;
                                err    <= 1'b0;
                            end
                        end
                        OP_DIV: begin
                            if (div_zero) begin
                                result <= {a_r, {WIDTH{1'b1}}};
                                err    <= 1'b1;
                            end else begin
                                rem   <= rem_next;
                                shreg <= quo_next;
                                cnt   <= cnt + CW'(1);
                                if (last_iter) begin
                                    result <= {rem_next, quo_next};
                                    err    <= 1'b0;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
